// File: rtl/mem_arb2.sv
// mem_arb2: two-requester arbiter/sequencer for a single-port register memory.
// One transaction at a time: IDLE -> ISSUE -> (WAIT for reads) -> ACK -> IDLE.
// Tie-break is round-robin on the last served requester; defining
// MEM_ARB_FIXED_PRIO_EN makes requester 0 win every tie instead.
module mem_arb2 #(
   parameter int AW = 2,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          ack0,
   output logic [DW-1:0] rdata0,
   output logic          ack1,
   output logic [DW-1:0] rdata1,
   output logic          gnt0,
   output logic          gnt1,
   output logic          busy,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      ACK   = 2'd3
   } state_t;

   state_t        state;
   state_t        state_next;
   logic          win;        // requester owning the current transaction
   logic          win_next;   // arbitration result, only meaningful in IDLE
   logic          last;       // requester served by the most recent completed transaction
   logic          take;       // a request is present while idle
   logic          cmd_we;
   logic [AW-1:0] cmd_addr;
   logic [DW-1:0] cmd_wdata;

   // Arbitration and next-state decode.
   always_comb begin
      take       = req0 | req1;
      win_next   = win;
      state_next = state;
      if (req0 && req1) begin
`ifdef MEM_ARB_FIXED_PRIO_EN
         win_next = 1'b0;
`else
         win_next = ~last;
`endif
      end else if (req0) begin
         win_next = 1'b0;
      end else if (req1) begin
         win_next = 1'b1;
      end
      case (state)
         IDLE:    if (take) state_next = ISSUE;
         ISSUE:   state_next = cmd_we ? ACK : WAIT;
         WAIT:    state_next = ACK;
         ACK:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register; reset drops any in-flight transaction.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Command capture: requester inputs are sampled only when leaving IDLE,
   // and the captured address/data double as the held memory port values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win       <= 1'b0;
         cmd_we    <= 1'b0;
         cmd_addr  <= '0;
         cmd_wdata <= '0;
      end else if (state == IDLE && take) begin
         win       <= win_next;
         cmd_we    <= win_next ? we1 : we0;
         cmd_addr  <= win_next ? addr1 : addr0;
         cmd_wdata <= win_next ? wdata1 : wdata0;
      end
   end

   // Round-robin pointer follows the requester just acknowledged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)            last <= 1'b1;
      else if (state == ACK) last <= win;
   end

   // Read data capture at the end of WAIT; each requester keeps its last read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata0 <= '0;
         rdata1 <= '0;
      end else if (state == WAIT) begin
         if (win) rdata1 <= mem_rdata;
         else     rdata0 <= mem_rdata;
      end
   end

   assign busy      = (state != IDLE);
   assign gnt0      = busy && !win;
   assign gnt1      = busy && win;
   assign ack0      = (state == ACK) && !win;
   assign ack1      = (state == ACK) && win;
   assign mem_we    = (state == ISSUE) && cmd_we;
   assign mem_addr  = cmd_addr;
   assign mem_wdata = cmd_wdata;

endmodule
